// File: rtl/led_breath_sched_pkg.sv
// Shared encodings and constants for the LED breathing scheduler.
package led_breath_sched_pkg;

  // Width of the chase channel pointer (enough for up to 8 channels).
  localparam int unsigned ChPtrW = 3;

  typedef enum logic [1:0] {
    MODE_BREATH = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Peak duty value for a given PWM width.
  function automatic int unsigned duty_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Encoding 3 is reserved and behaves like HOLD.
  function automatic mode_e decode_mode(input logic [1:0] sel);
    mode_e m;
    case (sel)
      2'd0:    m = MODE_BREATH;
      2'd1:    m = MODE_CHASE;
      default: m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_breath_sched_if.sv
// Control/status bundle between the board-side controller and the scheduler.
interface led_breath_sched_if
  import led_breath_sched_pkg::*;
#(
  parameter int unsigned N_CH = 6
);

  logic              en;
  logic [1:0]        mode_sel;
  logic [N_CH-1:0]   led;
  logic [ChPtrW-1:0] ch_ptr;
  logic              cycle_done;

  modport master (
    output en,
    output mode_sel,
    input  led,
    input  ch_ptr,
    input  cycle_done
  );

  modport slave (
    input  en,
    input  mode_sel,
    output led,
    output ch_ptr,
    output cycle_done
  );

endinterface

// File: rtl/led_breath_sched_tick_prescaler.sv
// Divides the system clock down to a one-cycle duty-step tick; frozen while disabled.
module led_breath_sched_tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap = (cnt_q == CntLast);
  // Gating by en_i means a tick coinciding with en falling is dropped.
  assign tick_o = en_i && wrap;

  // Next count: wrap at TICK_DIV-1, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_breath_sched.sv
// Breathing-pattern scheduler: triangle duty generator, channel selection and PWM drive.
module led_breath_sched
  import led_breath_sched_pkg::*;
#(
  parameter int unsigned N_CH     = 6,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  led_breath_sched_if.slave bus_if
);

  localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] DutyOne = PWM_BITS'(1);
  localparam logic [ChPtrW-1:0]   ChLast  = ChPtrW'(N_CH - 1);

  logic                tick;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  dir_e                dir_q, dir_d;
  mode_e               mode_q, mode_d;
  logic [ChPtrW-1:0]   ch_q, ch_d;
  logic                chase_sel_q, chase_sel_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_CH-1:0]     led_q, led_d;
  logic                cycle_done_q, cycle_done_d;
  logic                mode_sample;
  logic                single_sel;

  led_breath_sched_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .en_i  (bus_if.en),
    .tick_o(tick)
  );

  // Triangle FSM: dir is the state, duty ramps 0 -> MAX -> 0 one step per tick.
  always_comb begin
    duty_d       = duty_q;
    dir_d        = dir_q;
    cycle_done_d = 1'b0;
    if (tick && (mode_q != MODE_HOLD)) begin
      unique case (dir_q)
        DIR_UP: begin
          duty_d = duty_q + 1'b1;
          if (duty_q == DutyMax - 1'b1) begin
            dir_d = DIR_DOWN;
          end
        end
        DIR_DOWN: begin
          duty_d = duty_q - 1'b1;
          if (duty_q == DutyOne) begin
            dir_d        = DIR_UP;
            cycle_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Mode only changes at a zero crossing so brightness never jumps; idle-at-zero
  // keeps sampling, which is what lets HOLD be left again.
  always_comb begin
    mode_sample = cycle_done_d || ((duty_q == '0) && (dir_q == DIR_UP));
    mode_d      = mode_sample ? decode_mode(bus_if.mode_sel) : mode_q;
  end

  // Chase pointer and remembered selection style for HOLD.
  always_comb begin
    ch_d        = ch_q;
    chase_sel_d = chase_sel_q;
    if ((mode_d == MODE_CHASE) && (mode_q != MODE_CHASE)) begin
      ch_d = '0;
    end else if ((mode_q == MODE_CHASE) && cycle_done_d) begin
      ch_d = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
    end
    if (mode_q == MODE_BREATH) begin
      chase_sel_d = 1'b0;
    end else if (mode_q == MODE_CHASE) begin
      chase_sel_d = 1'b1;
    end
  end

  // PWM counter advances only while running.
  always_comb begin
    pwm_d = bus_if.en ? pwm_q + 1'b1 : pwm_q;
  end

  // PWM compare per channel; unselected channels see duty 0 and stay dark.
  always_comb begin
    single_sel = (mode_q == MODE_HOLD) ? chase_sel_q : (mode_q == MODE_CHASE);
    led_d      = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!single_sel || (ch_q == ChPtrW'(i))) begin
        led_d[i] = bus_if.en && (pwm_q < duty_q);
      end
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty_q       <= '0;
      dir_q        <= DIR_UP;
      mode_q       <= MODE_BREATH;
      ch_q         <= '0;
      chase_sel_q  <= 1'b0;
      pwm_q        <= '0;
      led_q        <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      duty_q       <= duty_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      ch_q         <= ch_d;
      chase_sel_q  <= chase_sel_d;
      pwm_q        <= pwm_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign bus_if.led        = led_q;
  assign bus_if.ch_ptr     = (mode_q == MODE_CHASE) ? ch_q : '0;
  assign bus_if.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breath_sched.sv
// Directed bench for led_breath_sched (TICK_DIV=4, PWM_BITS=3, MAX=7), plus a
// slow second instance (TICK_DIV=32) whose duty stays put long enough to count PWM.
module tb_led_breath_sched;
  import led_breath_sched_pkg::*;

  localparam int unsigned NCh     = 6;
  localparam int unsigned PwmBits = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic rst2_n;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int cnt0 [NCh];
  int cnt3 [NCh];
  int cnt7 [NCh];

  always #5 sys_clk = ~sys_clk;

  led_breath_sched_if #(.N_CH(NCh)) bus1 ();
  led_breath_sched_if #(.N_CH(NCh)) bus2 ();

  led_breath_sched #(
    .N_CH    (NCh),
    .PWM_BITS(PwmBits),
    .TICK_DIV(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus_if   (bus1)
  );

  led_breath_sched #(
    .N_CH    (NCh),
    .PWM_BITS(PwmBits),
    .TICK_DIV(32)
  ) dut2 (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst2_n),
    .bus_if   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_reset_state();
    check("rst_duty", 32'(dut.duty_q), 32'd0);
    check("rst_dir", 32'(dut.dir_q), 32'(DIR_UP));
    check("rst_mode", 32'(dut.mode_q), 32'(MODE_BREATH));
    check("rst_presc", 32'(dut.u_presc.cnt_q), 32'd0);
    check("rst_pwm", 32'(dut.pwm_q), 32'd0);
    check("rst_led", 32'(bus1.led), 32'd0);
    check("rst_ch_ptr", 32'(bus1.ch_ptr), 32'd0);
    check("rst_cycle_done", 32'(bus1.cycle_done), 32'd0);
  endtask

  // One full BREATH triangle right after reset release: 14 ticks, 56 clocks.
  task automatic run_triangle();
    int t;
    int exp_duty;
    int lit;
    lit = 0;
    for (int k = 1; k <= 56; k++) begin
      step(1);
      t        = k / 4;
      exp_duty = (t <= 7) ? t : 14 - t;
      check("tri_duty", 32'(dut.duty_q), 32'(exp_duty));
      check("tri_cycle_done", 32'(bus1.cycle_done), (k == 56) ? 32'd1 : 32'd0);
      check("tri_leds_equal", 32'((bus1.led == '0) || (bus1.led == '1)), 32'd1);
      if (bus1.led != '0) lit++;
      if (k == 28) check("tri_dir_at_peak", 32'(dut.dir_q), 32'(DIR_DOWN));
    end
    check("tri_some_lit", 32'(lit != 0), 32'd1);
  endtask

  initial begin
    logic [NCh-1:0] mask;
    int ch_exp;
    int leak;
    int lit;
    int pulses;
    int stray;

    sys_rst_n     = 1'b1;
    rst2_n        = 1'b1;
    bus1.en       = 1'b1;
    bus1.mode_sel = 2'd0;
    bus2.en       = 1'b1;
    bus2.mode_sel = 2'd0;
    #1;
    sys_rst_n = 1'b0;
    rst2_n    = 1'b0;
    step(2);

    // 1: reset values, then one BREATH triangle
    check_reset_state();
    sys_rst_n = 1'b1;
    run_triangle();

    // 3: CHASE over six triangles
    bus1.mode_sel = 2'd1;
    step(1);
    check("chase_mode", 32'(dut.mode_q), 32'(MODE_CHASE));
    check("chase_ptr_start", 32'(bus1.ch_ptr), 32'd0);
    check("chase_no_pulse", 32'(bus1.cycle_done), 32'd0);
    ch_exp = 0;
    for (int j = 0; j < 6; j++) begin
      leak   = 0;
      lit    = 0;
      pulses = 0;
      mask   = NCh'(1) << ch_exp;
      for (int c = 0; c < ((j == 0) ? 55 : 56); c++) begin
        step(1);
        if ((bus1.led & ~mask) != '0) leak++;
        if ((bus1.led & mask) != '0) lit++;
        if (bus1.cycle_done) pulses++;
      end
      check("chase_leak", 32'(leak), 32'd0);
      check("chase_lit", 32'(lit != 0), 32'd1);
      check("chase_pulses", 32'(pulses), 32'd1);
      check("chase_pulse_now", 32'(bus1.cycle_done), 32'd1);
      ch_exp = (j + 1) % 6;
      check("chase_ptr_step", 32'(bus1.ch_ptr), 32'(ch_exp));
    end

    // 4: BREATH, then request CHASE mid-ramp at duty 4
    bus1.mode_sel = 2'd0;
    step(1);
    check("m4_breath", 32'(dut.mode_q), 32'(MODE_BREATH));
    step(15);
    check("m4_duty4", 32'(dut.duty_q), 32'd4);
    check("m4_dir_up", 32'(dut.dir_q), 32'(DIR_UP));
    bus1.mode_sel = 2'd1;
    stray = 0;
    for (int c = 0; c < 39; c++) begin
      step(1);
      if (dut.mode_q != MODE_BREATH) stray++;
      if ((bus1.led != '0) && (bus1.led != '1)) stray++;
    end
    check("m4_mode_held", 32'(stray), 32'd0);
    check("m4_duty1", 32'(dut.duty_q), 32'd1);
    check("m4_dir_down", 32'(dut.dir_q), 32'(DIR_DOWN));
    step(1);
    check("m4_switched", 32'(dut.mode_q), 32'(MODE_CHASE));
    check("m4_ptr0", 32'(bus1.ch_ptr), 32'd0);
    check("m4_pulse", 32'(bus1.cycle_done), 32'd1);

    // 5: pause at duty 5 for 20 clocks
    step(20);
    check("p5_duty5", 32'(dut.duty_q), 32'd5);
    step(1);
    check("p5_led_pre", 32'(bus1.led), 32'h01);
    bus1.en = 1'b0;
    step(1);
    check("p5_led_blank", 32'(bus1.led), 32'd0);
    step(19);
    check("p5_duty_held", 32'(dut.duty_q), 32'd5);
    check("p5_dir_held", 32'(dut.dir_q), 32'(DIR_UP));
    check("p5_presc_held", 32'(dut.u_presc.cnt_q), 32'd1);
    check("p5_pwm_held", 32'(dut.pwm_q), 32'd5);
    check("p5_led_still", 32'(bus1.led), 32'd0);
    check("p5_no_pulse", 32'(bus1.cycle_done), 32'd0);
    bus1.en = 1'b1;
    step(2);
    check("p5_resume_5", 32'(dut.duty_q), 32'd5);
    step(1);
    check("p5_resume_6", 32'(dut.duty_q), 32'd6);
    step(32);
    check("p5_pulse", 32'(bus1.cycle_done), 32'd1);
    check("p5_ptr1", 32'(bus1.ch_ptr), 32'd1);
    check("p5_duty0", 32'(dut.duty_q), 32'd0);

    // 6: async reset mid-DOWN in BREATH
    bus1.mode_sel = 2'd0;
    step(1);
    check("r6_breath", 32'(dut.mode_q), 32'(MODE_BREATH));
    check("r6_ptr_zero", 32'(bus1.ch_ptr), 32'd0);
    step(36);
    check("r6_duty5", 32'(dut.duty_q), 32'd5);
    check("r6_dir_down", 32'(dut.dir_q), 32'(DIR_DOWN));
    check("r6_led_on", 32'(bus1.led), 32'h3f);
    sys_rst_n = 1'b0;
    #1;
    check_reset_state();
    step(1);
    sys_rst_n = 1'b1;
    run_triangle();

    // HOLD (and reserved encoding 3) at zero freezes, then BREATH resumes
    bus1.mode_sel = 2'd2;
    step(12);
    check("h_mode", 32'(dut.mode_q), 32'(MODE_HOLD));
    check("h_duty", 32'(dut.duty_q), 32'd0);
    check("h_led", 32'(bus1.led), 32'd0);
    bus1.mode_sel = 2'd3;
    step(12);
    check("h3_mode", 32'(dut.mode_q), 32'(MODE_HOLD));
    check("h3_duty", 32'(dut.duty_q), 32'd0);
    bus1.mode_sel = 2'd0;
    step(1);
    check("h_exit", 32'(dut.mode_q), 32'(MODE_BREATH));
    step(4);
    check("h_ramp", 32'(dut.duty_q), 32'd1);

    // 2: PWM lit counts over 8 clocks at duty 0, 3 and 7 (slow instance)
    for (int i = 0; i < int'(NCh); i++) begin
      cnt0[i] = 0;
      cnt3[i] = 0;
      cnt7[i] = 0;
    end
    rst2_n = 1'b1;
    for (int e = 1; e <= 233; e++) begin
      step(1);
      for (int i = 0; i < int'(NCh); i++) begin
        if (e >= 2 && e <= 9) cnt0[i] += int'(bus2.led[i]);
        if (e >= 98 && e <= 105) cnt3[i] += int'(bus2.led[i]);
        if (e >= 226 && e <= 233) cnt7[i] += int'(bus2.led[i]);
      end
    end
    for (int i = 0; i < int'(NCh); i++) begin
      check("pwm_duty0", 32'(cnt0[i]), 32'd0);
      check("pwm_duty3", 32'(cnt3[i]), 32'd3);
      check("pwm_duty7", 32'(cnt7[i]), 32'd7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
